// File: rtl/cpu_run_driver.sv
// Front-panel run/step sequencer: conditions the run/step/stop buttons and drives
// the CPU controller's start handshake and execution enable.
module cpu_run_driver #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_stop,
  input  logic             cpu_ready,
  input  logic             cpu_halt,
  output logic             start,
  output logic             enable,
  output logic [2:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    PAUSE  = 3'd4,
    HALTED = 3'd5
  } state_t;

  // Button bit order: 0 = run, 1 = step, 2 = stop.
  logic [2:0]            btn_raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d, deb_prev_q;
  logic [2:0][DEB_W-1:0] dcnt_q, dcnt_d;
  logic [2:0]            evt;
  logic                  run_evt, step_evt, stop_evt;

  state_t                state_q, state_d;
  logic                  run_flag_q, run_flag_d;
  logic                  start_q, start_d;
  logic                  enable_q, enable_d;
  logic [CNT_W-1:0]      count_q, count_d;

  assign btn_raw = {btn_stop, btn_step, btn_run};

  // A level change is accepted only after it survives the full debounce window.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q     <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
    end
  end

  assign evt      = deb_q & ~deb_prev_q;
  assign run_evt  = evt[0];
  assign step_evt = evt[1];
  assign stop_evt = evt[2];

  // Next state: stop beats step beats run; cpu_halt beats every button in RUN/STEP.
  always_comb begin
    state_d    = state_q;
    run_flag_d = run_flag_q;
    case (state_q)
      IDLE: begin
        if (step_evt) begin
          state_d    = LAUNCH;
          run_flag_d = 1'b0;
        end else if (run_evt) begin
          state_d    = LAUNCH;
          run_flag_d = 1'b1;
        end
      end
      LAUNCH: begin
        if (stop_evt) begin
          state_d = IDLE;
        end else if (cpu_ready) begin
          state_d = run_flag_q ? RUN : STEP;
        end
      end
      RUN: begin
        if (cpu_halt) begin
          state_d = HALTED;
        end else if (stop_evt || step_evt) begin
          state_d = PAUSE;
        end
      end
      STEP: begin
        state_d = cpu_halt ? HALTED : PAUSE;
      end
      PAUSE: begin
        if (stop_evt) begin
          state_d = IDLE;
        end else if (step_evt) begin
          state_d = STEP;
        end else if (run_evt) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        if (stop_evt) begin
          state_d = IDLE;
        end else if (step_evt) begin
          state_d    = LAUNCH;
          run_flag_d = 1'b0;
        end else if (run_evt) begin
          state_d    = LAUNCH;
          run_flag_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    start_d  = (state_d == LAUNCH);
    enable_d = (state_d == RUN) || (state_d == STEP);
    count_d  = count_q;
    if ((state_d == LAUNCH) && (state_q != LAUNCH)) begin
      count_d = '0;
    end else if (enable_q) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_flag_q <= 1'b0;
      start_q    <= 1'b0;
      enable_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_flag_q <= run_flag_d;
      start_q    <= start_d;
      enable_q   <= enable_d;
      count_q    <= count_d;
    end
  end

  assign start      = start_q;
  assign enable     = enable_q;
  assign mode       = state_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_cpu_run_driver.sv
// Directed bench for cpu_run_driver with DEB_CYCLES=4; a second instance with
// CNT_W=4 shares all inputs to observe step_count wrap-around.
module tb_cpu_run_driver;

  logic        clock;
  logic        reset;
  logic        btn_run, btn_step, btn_stop;
  logic        cpu_ready, cpu_halt;
  logic        start, enable;
  logic [2:0]  mode;
  logic [15:0] step_count;
  logic        start4, enable4;
  logic [2:0]  mode4;
  logic [3:0]  step_count4;

  int checks;
  int errors;
  int n;
  int hi;
  logic en_seen;

  cpu_run_driver #(.DEB_CYCLES(4), .DEB_W(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .btn_run(btn_run), .btn_step(btn_step), .btn_stop(btn_stop),
    .cpu_ready(cpu_ready), .cpu_halt(cpu_halt),
    .start(start), .enable(enable), .mode(mode), .step_count(step_count)
  );

  cpu_run_driver #(.DEB_CYCLES(4), .DEB_W(3), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .btn_run(btn_run), .btn_step(btn_step), .btn_stop(btn_stop),
    .cpu_ready(cpu_ready), .cpu_halt(cpu_halt),
    .start(start4), .enable(enable4), .mode(mode4), .step_count(step_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_mode(input logic [2:0] target, input string tag, output int cyc);
    cyc = 0;
    while (mode !== target && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_reached"}, 32'(mode), 32'(target));
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    btn_run = 1'b0; btn_step = 1'b0; btn_stop = 1'b0;
    cpu_ready = 1'b0; cpu_halt = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_start", 32'(start), 0);
    check("rst_enable", 32'(enable), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_count", 32'(step_count), 0);
    check("rst4_all", 32'({start4, enable4, mode4, step_count4}), 0);
    reset = 1'b1;
    tick();
    check("idle_after_release", 32'(mode), 0);

    // single step from IDLE with cpu_ready high
    cpu_ready = 1'b1;
    btn_step = 1'b1;
    wait_mode(3'd1, "step_launch", n);
    check("step_evt_latency", 32'(n), 7);
    check("step_launch_start", 32'(start), 1);
    check("step_launch_count", 32'(step_count), 0);
    tick();
    check("step_mode", 32'(mode), 3);
    check("step_enable", 32'(enable), 1);
    check("step_start_drop", 32'(start), 0);
    tick();
    check("step_pause_mode", 32'(mode), 4);
    check("step_pause_enable", 32'(enable), 0);
    check("step_count_one", 32'(step_count), 1);
    repeat (11) tick();
    btn_step = 1'b0;
    repeat (10) tick();
    check("step_held_mode", 32'(mode), 4);
    check("step_held_count", 32'(step_count), 1);

    // 3-cycle glitch must be filtered
    btn_step = 1'b1;
    repeat (3) tick();
    btn_step = 1'b0;
    repeat (12) tick();
    check("glitch_mode", 32'(mode), 4);
    check("glitch_count", 32'(step_count), 1);
    check("glitch_enable", 32'(enable), 0);

    // stop from PAUSE returns to IDLE
    btn_stop = 1'b1;
    wait_mode(3'd0, "pause_stop", n);
    check("pause_stop_start", 32'(start), 0);
    btn_stop = 1'b0;
    repeat (10) tick();

    // run with cpu_ready low for 5 LAUNCH cycles
    cpu_ready = 1'b0;
    btn_run = 1'b1;
    wait_mode(3'd1, "run_launch", n);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (start) hi++;
      if (i == 5) cpu_ready = 1'b1;
      if (mode !== 3'd1) break;
      tick();
    end
    check("launch_start_cycles", 32'(hi), 6);
    check("run_mode", 32'(mode), 2);
    check("run_enable", 32'(enable), 1);
    check("run_entry_count", 32'(step_count), 0);
    btn_run = 1'b0;
    repeat (100) tick();
    btn_stop = 1'b1;
    wait_mode(3'd4, "run_stop", n);
    check("stop_latency", 32'(n), 7);
    check("run_stop_enable", 32'(enable), 0);
    check("run_stop_count", 32'(step_count), 107);
    check("run_stop_count4", 32'(step_count4), 11);
    btn_stop = 1'b0;
    repeat (10) tick();

    // resume from PAUSE, then cpu_halt coincides with a stop event
    btn_run = 1'b1;
    wait_mode(3'd2, "resume_run", n);
    check("resume_latency", 32'(n), 7);
    check("resume_no_start", 32'(start), 0);
    check("resume_enable", 32'(enable), 1);
    btn_run = 1'b0;
    btn_stop = 1'b1;
    repeat (6) tick();
    check("pre_halt_mode", 32'(mode), 2);
    cpu_halt = 1'b1;
    tick();
    check("halt_mode", 32'(mode), 5);
    check("halt_enable", 32'(enable), 0);
    check("halt_count", 32'(step_count), 114);
    cpu_halt = 1'b0;
    btn_stop = 1'b0;
    repeat (10) tick();
    check("halted_hold_mode", 32'(mode), 5);

    // restart from HALTED, then step event in RUN pauses
    btn_run = 1'b1;
    wait_mode(3'd1, "restart_launch", n);
    check("restart_count_clear", 32'(step_count), 0);
    check("restart_start", 32'(start), 1);
    tick();
    check("restart_run", 32'(mode), 2);
    btn_run = 1'b0;
    btn_step = 1'b1;
    wait_mode(3'd4, "run_step_pause", n);
    check("run_step_count", 32'(step_count), 7);
    btn_step = 1'b0;
    repeat (10) tick();
    check("pause_hold", 32'(mode), 4);

    // simultaneous step and run events in PAUSE: step wins
    btn_step = 1'b1;
    btn_run = 1'b1;
    n = 0;
    while (mode === 3'd4 && n < 40) begin
      tick();
      n++;
    end
    check("simul_mode", 32'(mode), 3);
    check("simul_enable", 32'(enable), 1);
    check("simul_count_pre", 32'(step_count), 7);
    tick();
    check("simul_back_pause", 32'(mode), 4);
    check("simul_enable_drop", 32'(enable), 0);
    check("simul_count", 32'(step_count), 8);
    btn_step = 1'b0;
    btn_run = 1'b0;
    repeat (10) tick();

    // reset in the middle of RUN
    btn_run = 1'b1;
    wait_mode(3'd2, "pre_reset_run", n);
    btn_run = 1'b0;
    repeat (5) tick();
    check("pre_reset_enable", 32'(enable), 1);
    reset = 1'b0;
    tick();
    check("midrst_enable", 32'(enable), 0);
    check("midrst_mode", 32'(mode), 0);
    check("midrst_start", 32'(start), 0);
    check("midrst_count", 32'(step_count), 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_mode", 32'(mode), 0);
    check("post_rst_enable", 32'(enable), 0);

    // 17 enable cycles wrap a 4-bit counter to 1
    cpu_ready = 1'b1;
    btn_run = 1'b1;
    wait_mode(3'd1, "wrap_launch", n);
    tick();
    check("wrap_run", 32'(mode), 2);
    btn_run = 1'b0;
    repeat (16) tick();
    cpu_halt = 1'b1;
    tick();
    check("wrap_halt_mode", 32'(mode), 5);
    check("wrap_count16", 32'(step_count), 17);
    check("wrap_count4", 32'(step_count4), 1);
    check("wrap4_state", 32'({enable4, mode4}), 32'({1'b0, 3'd5}));
    cpu_halt = 1'b0;
    repeat (10) tick();

    // stop while waiting in LAUNCH: back to IDLE with no enable
    cpu_ready = 1'b0;
    btn_run = 1'b1;
    wait_mode(3'd1, "abort_launch", n);
    check("abort_launch_count", 32'(step_count), 0);
    btn_run = 1'b0;
    btn_stop = 1'b1;
    en_seen = 1'b0;
    n = 0;
    while (mode !== 3'd0 && n < 40) begin
      if (enable) en_seen = 1'b1;
      tick();
      n++;
    end
    if (enable) en_seen = 1'b1;
    check("abort_mode", 32'(mode), 0);
    check("abort_no_enable", 32'(en_seen), 0);
    check("abort_start", 32'(start), 0);
    check("abort_start4", 32'(start4), 0);
    btn_stop = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
